// File: rtl/scc_pkg.sv
// scc_pkg: constants shared by the SCC tone generator, channel sequencer and mixer
package scc_pkg;
  localparam int SCC_CH_NUM = 5;
  localparam int SCC_WAVE_W = 8;
  localparam int SCC_VOL_W  = 4;
  localparam int SCC_MIX_W  = 11;
endpackage

// File: rtl/scc_channel_mixer_if.sv
// scc_channel_mixer_if: channel-slot inputs and mixed-sample outputs of the mixer
interface scc_channel_mixer_if
  import scc_pkg::*;
#(
  parameter int OUT_W = SCC_MIX_W
);
  logic                         active;
  logic [2:0]                   channel_no;
  logic signed [SCC_WAVE_W-1:0] wave_data;
  logic [SCC_VOL_W-1:0]         reg_volume;
  logic                         reg_enable;
  logic signed [OUT_W-1:0]      sound_out;
  logic                         sound_valid;
  modport master (output active, channel_no, wave_data, reg_volume, reg_enable,
                  input sound_out, sound_valid);
  modport slave  (input active, channel_no, wave_data, reg_volume, reg_enable,
                  output sound_out, sound_valid);
endinterface

// File: rtl/scc_channel_volume.sv
// scc_channel_volume: scales a signed wave sample by a 4-bit volume, floored /16, gated by enable
module scc_channel_volume
  import scc_pkg::*;
(
  input  logic signed [SCC_WAVE_W-1:0] wave_data,
  input  logic [SCC_VOL_W-1:0]         reg_volume,
  input  logic                         reg_enable,
  output logic signed [SCC_WAVE_W-1:0] contribution
);
  logic signed [SCC_WAVE_W+SCC_VOL_W-1:0] product;
  assign product = wave_data * $signed({1'b0, reg_volume});
  // dropping the low nibble of a two's-complement product floors toward -inf
  assign contribution = reg_enable ? product[SCC_WAVE_W+SCC_VOL_W-1:SCC_VOL_W] : '0;
endmodule

// File: rtl/scc_channel_mixer.sv
// scc_channel_mixer: scales each channel slot and sums a frame of CH_NUM slots into one sample
module scc_channel_mixer
  import scc_pkg::*;
#(
  parameter int CH_NUM = SCC_CH_NUM,
  parameter int OUT_W  = SCC_MIX_W
)(
  input logic                clk,
  input logic                nreset,
  scc_channel_mixer_if.slave bus
);
  localparam logic [2:0] LAST = 3'(CH_NUM - 1);
  logic signed [SCC_WAVE_W-1:0] contrib, s1_contrib;
  logic [2:0]                   s1_ch;
  logic                         s1_valid;
  logic signed [OUT_W-1:0]      acc, ext, sum;
  scc_channel_volume u_vol (
    .wave_data   (bus.wave_data),
    .reg_volume  (bus.reg_volume),
    .reg_enable  (bus.reg_enable),
    .contribution(contrib)
  );
  assign ext = {{(OUT_W-SCC_WAVE_W){s1_contrib[SCC_WAVE_W-1]}}, s1_contrib};
  assign sum = acc + ext;
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      s1_valid   <= 1'b0;
      s1_ch      <= '0;
      s1_contrib <= '0;
    end else begin
      s1_valid <= bus.active && bus.channel_no <= LAST;
      if (bus.active && bus.channel_no <= LAST) begin
        s1_ch      <= bus.channel_no;
        s1_contrib <= contrib;
      end
    end
  end
  // the last slot publishes acc+contribution without touching acc; slot 0 restarts the frame
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      acc             <= '0;
      bus.sound_out   <= '0;
      bus.sound_valid <= 1'b0;
    end else begin
      bus.sound_valid <= s1_valid && s1_ch == LAST;
      if (s1_valid) begin
        if (s1_ch == 3'd0) acc <= ext;
        else if (s1_ch == LAST) bus.sound_out <= sum;
        else acc <= sum;
      end
    end
  end
endmodule
